// File: rtl/apb_master_pkg.sv
// -----------------------------------------------------------------------------
// apb_master_pkg
// Shared definitions for the APB3 requester and the blocks it talks to.
//   apb_state_e   : requester FSM state encoding (IDLE/SETUP/ACCESS)
//   I2C_REG_*     : register offsets of the I2C completer register block
//   wdog_width()  : width of the ACCESS-phase watchdog counter
// -----------------------------------------------------------------------------
package apb_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam logic [3:0] I2C_REG_TX      = 4'h0;
  localparam logic [3:0] I2C_REG_CONFIG  = 4'h4;
  localparam logic [3:0] I2C_REG_TIMEOUT = 4'h8;

  // clog2(timeout+1), but never narrower than one bit so that a disabled
  // watchdog (timeout == 0) still yields a legal counter declaration.
  function automatic int unsigned wdog_width(input int unsigned timeout);
    if (timeout == 0) return 1;
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/apb_master.sv
// -----------------------------------------------------------------------------
// apb_master
// APB3 requester. Turns single-beat commands into SETUP/ACCESS transfers,
// waits on PREADY and returns a one-cycle response pulse. A watchdog aborts
// transfers whose completer never raises PREADY.
// Ports:
//   PCLK, PRESETn                     clock, async active-low reset
//   cmd_valid/ready/write/addr/wdata  command channel (accept on valid & ready)
//   rsp_valid/rdata/err/timeout       response pulse, values held until next one
//   PSELx/PENABLE/PWRITE/PADDR/PWDATA APB request outputs (all registered)
//   PRDATA/PREADY/PSLVERR             APB completer inputs
// -----------------------------------------------------------------------------
module apb_master
  import apb_master_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSELx,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam int unsigned     CNT_W    = wdog_width(TIMEOUT_CYC);
  localparam bit              WDOG_EN  = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // Count value seen during the last permitted ACCESS cycle: the counter
  // would reach TIMEOUT_CYC on this edge, so the transfer is aborted here.
  localparam logic [CNT_W-1:0] CNT_LAST =
    WDOG_EN ? CNT_W'(TIMEOUT_CYC - 1) : '0;

  apb_state_e        state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic              wdog_expire;

  assign wdog_expire = WDOG_EN && (cnt_q == CNT_LAST);

  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    cnt_d         = cnt_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    unique case (state_q)
      ST_IDLE: begin
        // Command fields are only sampled here, so changes during a
        // transfer never reach the bus.
        if (cmd_valid) begin
          state_d  = ST_SETUP;
          psel_d   = 1'b1;
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ST_ACCESS: begin
        // PREADY is checked first so it wins over a simultaneous expiry.
        if (PREADY) begin
          state_d       = ST_IDLE;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
        end else if (wdog_expire) begin
          state_d       = ST_IDLE;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= ST_IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      cnt_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      cnt_q         <= cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // cmd_ready is the only combinational output.
  assign cmd_ready   = (state_q == ST_IDLE);
  assign PSELx       = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// -----------------------------------------------------------------------------
// tb_apb_master
// Directed bench for apb_master (TIMEOUT_CYC = 8). Outputs are sampled on the
// falling edge; inputs are driven away from the rising edge.
// -----------------------------------------------------------------------------
module tb_apb_master;

  logic        PCLK;
  logic        PRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        PSELx;
  logic        PENABLE;
  logic        PWRITE;
  logic [15:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int checks   = 0;
  int failures = 0;

  apb_master #(
    .ADDR_W     (16),
    .DATA_W     (32),
    .TIMEOUT_CYC(8)
  ) dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .PSELx      (PSELx),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #100000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  // Present one command on the falling edge, let it be accepted on the next
  // rising edge, then scramble the command inputs (they must be ignored).
  task automatic issue(input logic wr, input logic [15:0] a, input logic [31:0] d);
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    @(posedge PCLK);
    #1;
    cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = ~a; cmd_wdata = ~d;
  endtask

  // Completer side: counts falling edges until rsp_valid (bounded), counts
  // ACCESS cycles, raises PREADY in ACCESS cycle ready_at (0 = never) and
  // tallies bus samples that deviate from the accepted command.
  task automatic wait_rsp(input int ready_at, input logic exp_wr,
                          input logic [15:0] exp_addr, input logic [31:0] exp_wdata,
                          output bit got, output int lat, output int en_cnt,
                          output int bus_bad);
    got = 0; lat = 0; en_cnt = 0; bus_bad = 0;
    while (!got && lat < 40) begin
      @(negedge PCLK);
      lat++;
      if (rsp_valid === 1'b1) got = 1;
      else begin
        if (PSELx === 1'b1 &&
            (PADDR !== exp_addr || PWRITE !== exp_wr || PWDATA !== exp_wdata)) bus_bad++;
        if (PENABLE === 1'b1) begin
          en_cnt++;
          if (ready_at != 0 && en_cnt == ready_at) PREADY = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset();
    PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    repeat (3) @(negedge PCLK);
    checks++; if (PSELx !== 1'b0 || PENABLE !== 1'b0) begin failures++;
      $display("FAIL rst_psel_pen got=%b%b exp=00", PSELx, PENABLE); end
    checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0) begin failures++;
      $display("FAIL rst_rsp got=%b%b%b exp=000", rsp_valid, rsp_err, rsp_timeout); end
    checks++; if (PADDR !== 16'h0 || PWDATA !== 32'h0 || PWRITE !== 1'b0 || rsp_rdata !== 32'h0) begin
      failures++; $display("FAIL rst_data paddr=%h pwdata=%h pwrite=%b rdata=%h exp=0",
                           PADDR, PWDATA, PWRITE, rsp_rdata); end
    checks++; if (cmd_ready !== 1'b1) begin failures++;
      $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready); end
    PRESETn = 1'b1;
  endtask

  task automatic test_write_ready();
    PREADY = 1'b1; PRDATA = 32'h1234_5678; PSLVERR = 1'b0;
    issue(1'b1, 16'h0004, 32'h0000_1ABC);
    @(negedge PCLK);  // SETUP
    checks++; if (PSELx !== 1'b1 || PENABLE !== 1'b0) begin failures++;
      $display("FAIL wr_setup psel/pen got=%b%b exp=10", PSELx, PENABLE); end
    checks++; if (PADDR !== 16'h0004 || PWDATA !== 32'h0000_1ABC || PWRITE !== 1'b1) begin failures++;
      $display("FAIL wr_setup_bus paddr=%h pwdata=%h pwrite=%b exp 0004/00001abc/1",
               PADDR, PWDATA, PWRITE); end
    checks++; if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin failures++;
      $display("FAIL wr_setup_ready got rdy=%b rv=%b exp=0/0", cmd_ready, rsp_valid); end
    @(negedge PCLK);  // ACCESS
    checks++; if (PSELx !== 1'b1 || PENABLE !== 1'b1 || PADDR !== 16'h0004 || PWDATA !== 32'h0000_1ABC)
      begin failures++; $display("FAIL wr_access got sel=%b en=%b paddr=%h pwdata=%h",
                                 PSELx, PENABLE, PADDR, PWDATA); end
    @(negedge PCLK);  // response cycle, 3 cycles after accept
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'h0)
      begin failures++; $display("FAIL wr_rsp got v=%b e=%b t=%b d=%h exp 1/0/0/0",
                                 rsp_valid, rsp_err, rsp_timeout, rsp_rdata); end
    checks++; if (PSELx !== 1'b0 || PENABLE !== 1'b0 || cmd_ready !== 1'b1) begin failures++;
      $display("FAIL wr_rsp_bus got sel=%b en=%b rdy=%b exp 0/0/1", PSELx, PENABLE, cmd_ready); end
    PREADY = 1'b0;
    @(negedge PCLK);
    checks++; if (rsp_valid !== 1'b0 || PSELx !== 1'b0 || PADDR !== 16'h0004) begin failures++;
      $display("FAIL wr_after got v=%b sel=%b paddr=%h exp 0/0/0004", rsp_valid, PSELx, PADDR); end
  endtask

  task automatic test_read_wait();
    bit got; int lat, en, bad;
    PREADY = 1'b0; PRDATA = 32'hDEAD_BEEF;
    issue(1'b0, 16'h0008, 32'h0000_0000);
    wait_rsp(5, 1'b0, 16'h0008, 32'h0000_0000, got, lat, en, bad);
    PREADY = 1'b0;
    checks++; if (!got || lat != 7) begin failures++;
      $display("FAIL rd_latency got got=%0d lat=%0d exp 1/7", got, lat); end
    checks++; if (en != 5) begin failures++;
      $display("FAIL rd_penable_cycles got=%0d exp=5", en); end
    checks++; if (bad != 0) begin failures++;
      $display("FAIL rd_bus_stable got=%0d bad samples exp=0", bad); end
    checks++; if (rsp_rdata !== 32'hDEAD_BEEF || rsp_err !== 1'b0 || rsp_timeout !== 1'b0) begin
      failures++; $display("FAIL rd_rsp got d=%h e=%b t=%b exp deadbeef/0/0",
                           rsp_rdata, rsp_err, rsp_timeout); end
  endtask

  task automatic test_slverr();
    bit got; int lat, en, bad;
    PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'h0000_CAFE;
    issue(1'b1, 16'h0000, 32'h0000_0055);
    wait_rsp(1, 1'b1, 16'h0000, 32'h0000_0055, got, lat, en, bad);
    PREADY = 1'b0; PSLVERR = 1'b0;
    checks++; if (!got || lat != 3) begin failures++;
      $display("FAIL err_latency got got=%0d lat=%0d exp 1/3", got, lat); end
    checks++; if (rsp_err !== 1'b1 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'h0) begin failures++;
      $display("FAIL err_rsp got e=%b t=%b d=%h exp 1/0/0", rsp_err, rsp_timeout, rsp_rdata); end
    @(negedge PCLK);
    checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b1) begin failures++;
      $display("FAIL err_hold got v=%b e=%b exp 0/1", rsp_valid, rsp_err); end
  endtask

  task automatic test_timeout();
    bit got; int lat, en, bad;
    PREADY = 1'b0; PRDATA = 32'h5555_AAAA;
    issue(1'b1, 16'h0004, 32'h0000_0077);
    wait_rsp(0, 1'b1, 16'h0004, 32'h0000_0077, got, lat, en, bad);
    checks++; if (!got || lat != 10 || en != 8) begin failures++;
      $display("FAIL to_abort_timing got got=%0d lat=%0d en=%0d exp 1/10/8", got, lat, en); end
    checks++; if (rsp_err !== 1'b1 || rsp_timeout !== 1'b1 || rsp_rdata !== 32'h0) begin failures++;
      $display("FAIL to_abort_rsp got e=%b t=%b d=%h exp 1/1/0", rsp_err, rsp_timeout, rsp_rdata); end
    checks++; if (PSELx !== 1'b0 || PENABLE !== 1'b0 || cmd_ready !== 1'b1) begin failures++;
      $display("FAIL to_abort_bus got sel=%b en=%b rdy=%b exp 0/0/1", PSELx, PENABLE, cmd_ready); end
    // PREADY arrives in the 8th ACCESS cycle: normal completion wins.
    PRDATA = 32'h0BAD_F00D;
    issue(1'b0, 16'h000C, 32'h0000_0000);
    wait_rsp(8, 1'b0, 16'h000C, 32'h0000_0000, got, lat, en, bad);
    PREADY = 1'b0;
    checks++; if (!got || lat != 10 || en != 8 || bad != 0) begin failures++;
      $display("FAIL to_edge_timing got got=%0d lat=%0d en=%0d bad=%0d exp 1/10/8/0",
               got, lat, en, bad); end
    checks++; if (rsp_err !== 1'b0 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'h0BAD_F00D) begin
      failures++; $display("FAIL to_edge_rsp got e=%b t=%b d=%h exp 0/0/0badf00d",
                           rsp_err, rsp_timeout, rsp_rdata); end
  endtask

  task automatic test_back_to_back();
    logic        psel_h [16];
    logic        rv_h   [16];
    logic [15:0] pa_h   [16];
    int          acc_t  [3];
    int          idx;
    logic [15:0] addrs  [3];
    addrs[0] = 16'h0010; addrs[1] = 16'h0014; addrs[2] = 16'h0018;
    acc_t[0] = -1; acc_t[1] = -1; acc_t[2] = -1;
    PREADY = 1'b1;
    @(negedge PCLK);
    idx = 0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = addrs[0]; cmd_wdata = 32'h100;
    for (int k = 0; k < 16; k++) begin
      psel_h[k] = PSELx; rv_h[k] = rsp_valid; pa_h[k] = PADDR;
      if (cmd_valid && cmd_ready) begin
        acc_t[idx] = k;
        @(posedge PCLK);
        #1;
        idx++;
        if (idx < 3) begin cmd_addr = addrs[idx]; cmd_wdata = 32'h100 + idx; end
        else cmd_valid = 1'b0;
      end
      @(negedge PCLK);
    end
    PREADY = 1'b0;
    checks++; if (acc_t[0] != 0 || acc_t[1] != 3 || acc_t[2] != 6) begin failures++;
      $display("FAIL b2b_accept_times got=%0d,%0d,%0d exp 0,3,6", acc_t[0], acc_t[1], acc_t[2]); end
    for (int k = 1; k < 13; k++) begin
      checks++; if (psel_h[k] !== ((k % 3) != 0 && k < 10)) begin failures++;
        $display("FAIL b2b_psel cycle=%0d got=%b exp=%b", k, psel_h[k], ((k % 3) != 0 && k < 10)); end
      checks++; if (rv_h[k] !== (k == 3 || k == 6 || k == 9)) begin failures++;
        $display("FAIL b2b_rsp_valid cycle=%0d got=%b exp=%b", k, rv_h[k], (k == 3 || k == 6 || k == 9)); end
    end
    for (int i = 0; i < 3; i++) begin
      checks++; if (pa_h[3*i+1] !== addrs[i]) begin failures++;
        $display("FAIL b2b_paddr xfer=%0d got=%h exp=%h", i, pa_h[3*i+1], addrs[i]); end
    end
  endtask

  task automatic test_reset_mid();
    bit got; int lat, en, bad; int waited;
    PREADY = 1'b0;
    issue(1'b0, 16'h0020, 32'h0000_0000);
    waited = 0;
    do begin @(negedge PCLK); waited++; end while (PENABLE !== 1'b1 && waited < 10);
    checks++; if (PENABLE !== 1'b1) begin failures++;
      $display("FAIL rstm_reach_access got=%b exp=1", PENABLE); end
    #2 PRESETn = 1'b0;
    #1;
    checks++; if (PSELx !== 1'b0 || PENABLE !== 1'b0 || rsp_valid !== 1'b0) begin failures++;
      $display("FAIL rstm_immediate got sel=%b en=%b rv=%b exp 0/0/0", PSELx, PENABLE, rsp_valid); end
    checks++; if (PADDR !== 16'h0) begin failures++;
      $display("FAIL rstm_paddr got=%h exp=0000", PADDR); end
    PREADY = 1'b1;
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge PCLK);
      checks++; if (rsp_valid !== 1'b0 || PSELx !== 1'b0 || cmd_ready !== 1'b1) begin failures++;
        $display("FAIL rstm_idle cycle=%0d got rv=%b sel=%b rdy=%b exp 0/0/1",
                 k, rsp_valid, PSELx, cmd_ready); end
    end
    issue(1'b1, 16'h0024, 32'h0000_0099);
    wait_rsp(1, 1'b1, 16'h0024, 32'h0000_0099, got, lat, en, bad);
    PREADY = 1'b0;
    checks++; if (!got || lat != 3 || bad != 0 || rsp_err !== 1'b0) begin failures++;
      $display("FAIL rstm_recover got got=%0d lat=%0d bad=%0d err=%b exp 1/3/0/0",
               got, lat, bad, rsp_err); end
  endtask

  initial begin
    test_reset();
    test_write_ready();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge PCLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
